game_screen_ctrl: RTL and testbench
===================================

GAME_SCREEN_CTRL -- requirements
Module: game_screen_ctrl

Interface
REQ-001 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-002 SHALL have parameter DIV_LOG2, default 2, pixel strobe period = 2^DIV_LOG2 clocks (0..8).
REQ-003 SHALL have parameter END_FRAMES, default 120, frames spent in END before auto-return to START; 0 disables auto-return (1..255 otherwise).
REQ-004 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports start_game, reset_game, pause_game  input  1 each  level button inputs.
REQ-007 SHALL have port end_game  input  1  collision/game-over level from the game core.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at the first pixel of each frame.
REQ-009 SHALL have port active  input  1  high during visible pixels.
REQ-010 SHALL have ports start_rgb, play_rgb, end_rgb  input  3*COLOR_W each  packed {R,G,B} per screen source.
REQ-011 SHALL have port pix_stb  output  1  pixel strobe.
REQ-012 SHALL have port current_state  output  2  logical game state.
REQ-013 SHALL have port shown_state  output  2  state currently displayed.
REQ-014 SHALL have ports VGA_R, VGA_G, VGA_B  output  COLOR_W each  registered colour.
REQ-015 SHALL have port state_chg  output  1  one-cycle pulse on every current_state change.

Function
REQ-016 States SHALL be encoded START=0, PLAY=1, END=2, PAUSE=3.
REQ-017 start_game, reset_game, pause_game SHALL each be registered once and act only on a rising edge (0->1 between consecutive clocks).
REQ-018 reset_game edge SHALL force START from any state, overriding all other events in that cycle.
REQ-019 START: start edge -> PLAY.
REQ-020 PLAY: end_game high -> END; else pause edge -> PAUSE (end_game wins when simultaneous).
REQ-021 PAUSE: pause edge or start edge -> PLAY; end_game ignored in PAUSE.
REQ-022 END: start edge -> PLAY; else when END_FRAMES!=0, after END_FRAMES frame_start pulses counted in END -> START.
REQ-023 Frame counter SHALL clear on every entry to END and saturate, never wrap.
REQ-024 shown_state SHALL load current_state only in the cycle frame_start is high, so screens switch on frame boundaries only.
REQ-025 Colour source SHALL be: START->start_rgb, PLAY->play_rgb, END->end_rgb, PAUSE->play_rgb with each channel shifted right by 1 (half brightness).
REQ-026 VGA_R/G/B SHALL be registered, one clock latency from inputs; zero whenever active is low.
REQ-027 pix_stb SHALL be high one clock in every 2^DIV_LOG2 clocks, from a free-running DIV_LOG2-bit counter wrapping at all-ones; DIV_LOG2=0 gives constant high.
REQ-028 state_chg SHALL pulse in the clock after current_state updates, never for a self-transition.

Reset
REQ-029 With RST low: current_state=START, shown_state=START, edge registers=0, frame counter=0, divider=0, VGA_R/G/B=0, pix_stb=0, state_chg=0.
REQ-030 Reset deassertion mid-frame SHALL show START until the next frame_start keeps it there; no spurious state_chg.
REQ-031 Buttons held high through reset deassertion SHALL not count as an edge.

Configuration
REQ-032 Macro GAME_PAUSE_EN SHALL compile in the PAUSE state and pause_game handling.
REQ-033 Without GAME_PAUSE_EN: pause_game unused, PAUSE unreachable, state 3 never produced; if ever seen, output white (all ones).

Verification
REQ-034 RST low 5 clocks, release -> current_state=0, RGB=0, state_chg=0.
REQ-035 START, start edge -> state 1 next clock, state_chg pulse; shown_state stays 0 until frame_start, then 1.
REQ-036 PLAY, end_game=1 and pause edge same cycle -> state 2; END_FRAMES=3, 3 frame_start pulses -> state 0.
REQ-037 PLAY, pause edge (GAME_PAUSE_EN) -> state 3; play_rgb=12'hF84 -> RGB 7,4,2 after frame_start; second pause edge -> PLAY.
REQ-038 Any state, reset_game and start edge together -> state 0.
REQ-039 DIV_LOG2=2 -> pix_stb high exactly every 4th clock; active=0 -> RGB=0 one clock later.

Source files
------------

// File: rtl/game_screen_ctrl.sv
// Game screen controller: button-driven START/PLAY/END state machine, frame-aligned
// screen switching, registered VGA colour mux and pixel strobe. Define GAME_PAUSE_EN for PAUSE.
module game_screen_ctrl #(
    parameter int COLOR_W    = 4,
    parameter int DIV_LOG2   = 2,
    parameter int END_FRAMES = 120
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start_game,
    input  logic                   reset_game,
    input  logic                   pause_game,
    input  logic                   end_game,
    input  logic                   frame_start,
    input  logic                   active,
    input  logic [3*COLOR_W-1:0]   start_rgb,
    input  logic [3*COLOR_W-1:0]   play_rgb,
    input  logic [3*COLOR_W-1:0]   end_rgb,
    output logic                   pix_stb,
    output logic [1:0]             current_state,
    output logic [1:0]             shown_state,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   state_chg
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_END   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [7:0] END_LIM = 8'(END_FRAMES);

    state_t               state_q, state_d, shown_q, shown_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 chg_q, chg_d;
    logic                 start_q, reset_q, armed_q;
    logic                 start_edge, reset_edge, pause_edge;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d, sel_rgb;
    logic                 stb_q, stb_d;

`ifdef GAME_PAUSE_EN
    logic pause_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) pause_q <= 1'b0;
        else      pause_q <= pause_game;
    end

    assign pause_edge = pause_game & ~pause_q & armed_q;
`else
    logic unused_pause;
    assign unused_pause = pause_game;
    assign pause_edge   = 1'b0;
`endif

    // armed_q masks the first clock after reset so held buttons are not edges
    assign start_edge = start_game & ~start_q & armed_q;
    assign reset_edge = reset_game & ~reset_q & armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_END && frame_start && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
        case (state_q)
            ST_START: if (start_edge) state_d = ST_PLAY;
            ST_PLAY: begin
                if (end_game)        state_d = ST_END;
                else if (pause_edge) state_d = ST_PAUSE;
            end
            ST_END: begin
                if (start_edge)
                    state_d = ST_PLAY;
                else if (END_FRAMES != 0 && frame_start &&
                         ({1'b0, cnt_q} + 9'd1) >= {1'b0, END_LIM})
                    state_d = ST_START;
            end
            default: begin
`ifdef GAME_PAUSE_EN
                if (pause_edge || start_edge) state_d = ST_PLAY;
`else
                state_d = ST_START;
`endif
            end
        endcase
        if (reset_edge) state_d = ST_START;
        if (state_d == ST_END && state_q != ST_END) cnt_d = 8'd0;
        chg_d   = (state_d != state_q);
        shown_d = frame_start ? state_q : shown_q;
    end

`ifdef GAME_PAUSE_EN
    logic [COLOR_W-1:0] half_r, half_g, half_b;
    assign half_r = play_rgb[3*COLOR_W-1:2*COLOR_W] >> 1;
    assign half_g = play_rgb[2*COLOR_W-1:COLOR_W] >> 1;
    assign half_b = play_rgb[COLOR_W-1:0] >> 1;
`endif

    always_comb begin
        sel_rgb = '1;
        case (shown_q)
            ST_START: sel_rgb = start_rgb;
            ST_PLAY:  sel_rgb = play_rgb;
            ST_END:   sel_rgb = end_rgb;
            default: begin
`ifdef GAME_PAUSE_EN
                sel_rgb = {half_r, half_g, half_b};
`else
                sel_rgb = '1;
`endif
            end
        endcase
        rgb_d = active ? sel_rgb : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_START;
            shown_q <= ST_START;
            cnt_q   <= 8'd0;
            chg_q   <= 1'b0;
            start_q <= 1'b0;
            reset_q <= 1'b0;
            armed_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            shown_q <= shown_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            start_q <= start_game;
            reset_q <= reset_game;
            armed_q <= 1'b1;
            rgb_q   <= rgb_d;
        end
    end

    generate
        if (DIV_LOG2 == 0) begin : g_nodiv
            assign stb_d = 1'b1;
        end else begin : g_div
            logic [DIV_LOG2-1:0] div_q, div_d;
            assign div_d = div_q + DIV_LOG2'(1);
            assign stb_d = &div_q;
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) div_q <= '0;
                else      div_q <= div_d;
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stb_q <= 1'b0;
        else      stb_q <= stb_d;
    end

    assign pix_stb       = stb_q;
    assign current_state = state_q;
    assign shown_state   = shown_q;
    assign state_chg     = chg_q;
    assign VGA_R         = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign VGA_G         = rgb_q[2*COLOR_W-1:COLOR_W];
    assign VGA_B         = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed testbench for game_screen_ctrl (COLOR_W=4, DIV_LOG2=2, END_FRAMES=3).
module tb_game_screen_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_game, reset_game, pause_game, end_game, frame_start, active;
    logic [11:0] start_rgb, play_rgb, end_rgb;
    logic        pix_stb, state_chg;
    logic [1:0]  current_state, shown_state;
    logic [3:0]  VGA_R, VGA_G, VGA_B;

    int checks = 0;
    int errors = 0;

    game_screen_ctrl #(.COLOR_W(4), .DIV_LOG2(2), .END_FRAMES(3)) dut (
        .CLK(CLK), .RST(RST),
        .start_game(start_game), .reset_game(reset_game), .pause_game(pause_game),
        .end_game(end_game), .frame_start(frame_start), .active(active),
        .start_rgb(start_rgb), .play_rgb(play_rgb), .end_rgb(end_rgb),
        .pix_stb(pix_stb), .current_state(current_state), .shown_state(shown_state),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .state_chg(state_chg)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        start_game = 1'b1;
        reset_game = 1'b0; pause_game = 1'b0; end_game = 1'b0;
        frame_start = 1'b0; active = 1'b0;
        start_rgb = 12'h123; play_rgb = 12'h5A3; end_rgb = 12'hE71;
        repeat (5) tick();
        checks++;
        if ({current_state, shown_state, VGA_R, VGA_G, VGA_B, pix_stb, state_chg} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%0d sh=%0d rgb=%h%h%h stb=%b chg=%b, expected all zero",
                     current_state, shown_state, VGA_R, VGA_G, VGA_B, pix_stb, state_chg);
        end
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if (current_state !== 2'd0) begin
            errors++;
            $display("FAIL held_start_after_reset: state=%0d expected 0", current_state);
        end
        checks++;
        if (state_chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_chg: state_chg=%b expected 0", state_chg);
        end
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: rgb=%h%h%h expected 000", VGA_R, VGA_G, VGA_B);
        end
        start_game = 1'b0;
        tick();
    endtask

    task automatic test_start();
        active = 1'b1;
        start_game = 1'b1;
        tick();
        checks++;
        if (current_state !== 2'd1 || state_chg !== 1'b1) begin
            errors++;
            $display("FAIL start_to_play: state=%0d chg=%b expected 1/1", current_state, state_chg);
        end
        start_game = 1'b0;
        tick();
        checks++;
        if (state_chg !== 1'b0 || shown_state !== 2'd0) begin
            errors++;
            $display("FAIL start_chg_shown: chg=%b shown=%0d expected 0/0", state_chg, shown_state);
        end
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h123) begin
            errors++;
            $display("FAIL start_screen_rgb: rgb=%h%h%h expected 123", VGA_R, VGA_G, VGA_B);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (shown_state !== 2'd1) begin
            errors++;
            $display("FAIL shown_after_frame: shown=%0d expected 1", shown_state);
        end
        tick();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h5A3) begin
            errors++;
            $display("FAIL play_rgb: rgb=%h%h%h expected 5a3", VGA_R, VGA_G, VGA_B);
        end
    endtask

    task automatic test_end_autoreturn();
        end_game = 1'b1;
        pause_game = 1'b1;
        tick();
        checks++;
        if (current_state !== 2'd2 || state_chg !== 1'b1) begin
            errors++;
            $display("FAIL end_wins_over_pause: state=%0d chg=%b expected 2/1", current_state, state_chg);
        end
        end_game = 1'b0;
        pause_game = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            checks++;
            if (current_state !== ((i == 3) ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL end_frame_count_%0d: state=%0d expected %0d",
                         i, current_state, (i == 3) ? 0 : 2);
            end
            tick();
            if (i == 1) begin
                checks++;
                if (shown_state !== 2'd2 || {VGA_R, VGA_G, VGA_B} !== 12'hE71) begin
                    errors++;
                    $display("FAIL end_screen: shown=%0d rgb=%h%h%h expected 2/e71",
                             shown_state, VGA_R, VGA_G, VGA_B);
                end
            end
        end
    endtask

    task automatic test_pause();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        tick();
        play_rgb = 12'hF84;
        pause_game = 1'b1;
        tick();
`ifdef GAME_PAUSE_EN
        checks++;
        if (current_state !== 2'd3 || state_chg !== 1'b1) begin
            errors++;
            $display("FAIL play_to_pause: state=%0d chg=%b expected 3/1", current_state, state_chg);
        end
        pause_game = 1'b0;
        end_game = 1'b1;
        tick();
        end_game = 1'b0;
        checks++;
        if (current_state !== 2'd3) begin
            errors++;
            $display("FAIL pause_ignores_end: state=%0d expected 3", current_state);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h742) begin
            errors++;
            $display("FAIL pause_half_rgb: rgb=%h%h%h expected 742", VGA_R, VGA_G, VGA_B);
        end
        pause_game = 1'b1;
        tick();
        checks++;
        if (current_state !== 2'd1) begin
            errors++;
            $display("FAIL pause_to_play: state=%0d expected 1", current_state);
        end
`else
        checks++;
        if (current_state !== 2'd1 || state_chg !== 1'b0) begin
            errors++;
            $display("FAIL pause_disabled: state=%0d chg=%b expected 1/0", current_state, state_chg);
        end
`endif
        pause_game = 1'b0;
        tick();
    endtask

    task automatic test_reset_game();
        reset_game = 1'b1;
        start_game = 1'b1;
        tick();
        checks++;
        if (current_state !== 2'd0 || state_chg !== 1'b1) begin
            errors++;
            $display("FAIL reset_game_from_play: state=%0d chg=%b expected 0/1", current_state, state_chg);
        end
        reset_game = 1'b0;
        start_game = 1'b0;
        tick();
        reset_game = 1'b1;
        start_game = 1'b1;
        tick();
        checks++;
        if (current_state !== 2'd0 || state_chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_game_over_start: state=%0d chg=%b expected 0/0", current_state, state_chg);
        end
        reset_game = 1'b0;
        start_game = 1'b0;
        tick();
    endtask

    task automatic test_active();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        start_rgb = 12'h9C6;
        tick();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h9C6) begin
            errors++;
            $display("FAIL active_rgb: rgb=%h%h%h expected 9c6", VGA_R, VGA_G, VGA_B);
        end
        active = 1'b0;
        #1;
        checks++;
        if (VGA_R !== 4'h9) begin
            errors++;
            $display("FAIL rgb_registered: R=%h expected 9 before clock", VGA_R);
        end
        tick();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL blank_rgb: rgb=%h%h%h expected 000", VGA_R, VGA_G, VGA_B);
        end
    endtask

    task automatic test_pix_stb();
        int highs = 0;
        int last  = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pix_stb === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last !== 4) begin
                        errors++;
                        $display("FAIL pix_stb_spacing: gap=%0d expected 4", i - last);
                    end
                end
                last = i;
                highs++;
            end
        end
        checks++;
        if (highs !== 4) begin
            errors++;
            $display("FAIL pix_stb_count: highs=%0d expected 4 in 16 clocks", highs);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_end_autoreturn();
        test_pause();
        test_reset_game();
        test_active();
        test_pix_stb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
